// File: rtl/slv_guard_cfg_regs.sv
// Slave guard configuration registers: reg-bus target, W1C status, counters, IRQ.
// Optional CTRL lock bit enabled by defining GUARD_CFG_LOCK_EN.
module slv_guard_cfg_regs #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned CntWidth  = 10,
  parameter logic [31:0] IdValue   = 32'h5647_0001
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic                 reg_write_i,
  input  logic [DataWidth-1:0] reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  input  logic                 reg_valid_i,
  output logic [DataWidth-1:0] reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 reg_ready_o,
  input  logic                 wr_timeout_i,
  input  logic                 rd_timeout_i,
  output logic                 guard_en_o,
  output logic [CntWidth-1:0]  wr_budget_o,
  output logic [CntWidth-1:0]  rd_budget_o,
  output logic                 irq_o
);

  if (DataWidth != 32) begin : g_dw_chk
    $fatal(1, "DataWidth must be 32");
  end
  if (CntWidth < 1 || CntWidth > 32) begin : g_cw_chk
    $fatal(1, "CntWidth must be 1..32");
  end
  if (AddrWidth < 8) begin : g_aw_chk
    $fatal(1, "AddrWidth must be >= 8");
  end

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  state_e state_q, state_d;

  logic [7:0]          addr_q;
  logic                write_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                ctrl_en_q;
  logic [CntWidth-1:0] wr_budget_q;
  logic [CntWidth-1:0] rd_budget_q;
  logic [1:0]          status_q;
  logic [1:0]          irq_en_q;
  logic [15:0]         wr_cnt_q;
  logic [15:0]         rd_cnt_q;
  logic                irq_q;
  logic                lock_q;

  logic sel_ctrl, sel_wrb, sel_rdb, sel_stat;
  logic sel_irqen, sel_evt, sel_id;
  logic lock_blk, err, ready, commit;
  logic [31:0] bmask, rd_val;
  logic [1:0]  stat_clr;
  logic        unused_bits;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and response strobe
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    unique case (state_q)
      S_IDLE: if (reg_valid_i) state_d = S_RESP;
      S_RESP: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture; the master holds fields until ready
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (state_q == S_IDLE && reg_valid_i) begin
      addr_q  <= reg_addr_i[7:0];
      write_q <= reg_write_i;
      wdata_q <= reg_wdata_i;
      wstrb_q <= reg_wstrb_i;
    end
  end

  assign sel_ctrl  = addr_q == 8'h00;
  assign sel_wrb   = addr_q == 8'h04;
  assign sel_rdb   = addr_q == 8'h08;
  assign sel_stat  = addr_q == 8'h0C;
  assign sel_irqen = addr_q == 8'h10;
  assign sel_evt   = addr_q == 8'h14;
  assign sel_id    = addr_q == 8'h18;

  assign lock_blk = lock_q && write_q &&
                    (sel_ctrl || sel_wrb || sel_rdb || sel_irqen);
  assign err = (addr_q[1:0] != 2'b00) || (addr_q > 8'h18) ||
               (write_q && sel_id) || lock_blk;
  assign commit = ready && write_q && !err;

  assign bmask = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}},
                  {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};
  assign stat_clr = (commit && sel_stat) ?
                    (wdata_q[1:0] & bmask[1:0]) : 2'b00;

  // Read mux over the decoded register
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      sel_ctrl:  rd_val = {lock_q, 30'd0, ctrl_en_q};
      sel_wrb:   rd_val = 32'(wr_budget_q);
      sel_rdb:   rd_val = 32'(rd_budget_q);
      sel_stat:  rd_val = {30'd0, status_q};
      sel_irqen: rd_val = {30'd0, irq_en_q};
      sel_evt:   rd_val = {rd_cnt_q, wr_cnt_q};
      sel_id:    rd_val = IdValue;
      default:   rd_val = '0;
    endcase
  end

  assign reg_ready_o = ready;
  assign reg_error_o = ready && err;
  assign reg_rdata_o = (ready && !write_q && !err) ? rd_val : '0;

  // Read/write control registers, byte-strobed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_en_q   <= 1'b0;
      wr_budget_q <= '0;
      rd_budget_q <= '0;
      irq_en_q    <= '0;
    end else if (commit) begin
      if (sel_ctrl && wstrb_q[0]) ctrl_en_q <= wdata_q[0];
      if (sel_wrb)
        wr_budget_q <= (wr_budget_q & ~bmask[CntWidth-1:0]) |
                       (wdata_q[CntWidth-1:0] & bmask[CntWidth-1:0]);
      if (sel_rdb)
        rd_budget_q <= (rd_budget_q & ~bmask[CntWidth-1:0]) |
                       (wdata_q[CntWidth-1:0] & bmask[CntWidth-1:0]);
      if (sel_irqen)
        irq_en_q <= (irq_en_q & ~bmask[1:0]) | (wdata_q[1:0] & bmask[1:0]);
    end
  end

`ifdef GUARD_CFG_LOCK_EN
  // Lock bit: set by software, cleared only by reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lock_q <= 1'b0;
    else if (commit && sel_ctrl && wstrb_q[3] && wdata_q[31]) lock_q <= 1'b1;
  end
`else
  assign lock_q = 1'b0;
`endif

  // Sticky status: a new event beats a same-cycle clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) status_q <= '0;
    else status_q <= (status_q & ~stat_clr) | {rd_timeout_i, wr_timeout_i};
  end

  // Saturating event counters; clear plus event lands on 1
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else if (commit && sel_evt) begin
      wr_cnt_q <= {15'd0, wr_timeout_i};
      rd_cnt_q <= {15'd0, rd_timeout_i};
    end else begin
      if (wr_timeout_i && wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (rd_timeout_i && rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  // Registered interrupt from enabled status bits
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_q <= 1'b0;
    else       irq_q <= |(status_q & irq_en_q);
  end

  assign guard_en_o  = ctrl_en_q;
  assign wr_budget_o = wr_budget_q;
  assign rd_budget_o = rd_budget_q;
  assign irq_o       = irq_q;

  assign unused_bits = ^{reg_addr_i, wdata_q, bmask};

endmodule

// File: tb/tb_slv_guard_cfg_regs.sv
// Bench for slv_guard_cfg_regs: directed accesses, queued expected responses.
// A negedge monitor pops and compares each ready pulse.
module tb_slv_guard_cfg_regs;

  localparam logic [31:0] ID = 32'h5647_0001;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] reg_addr_i = '0;
  logic        reg_write_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic [3:0]  reg_wstrb_i = '0;
  logic        reg_valid_i = 1'b0;
  logic [31:0] reg_rdata_o;
  logic        reg_error_o;
  logic        reg_ready_o;
  logic        wr_timeout_i = 1'b0;
  logic        rd_timeout_i = 1'b0;
  logic        guard_en_o;
  logic [9:0]  wr_budget_o;
  logic [9:0]  rd_budget_o;
  logic        irq_o;

  slv_guard_cfg_regs dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .reg_addr_i(reg_addr_i), .reg_write_i(reg_write_i),
    .reg_wdata_i(reg_wdata_i), .reg_wstrb_i(reg_wstrb_i),
    .reg_valid_i(reg_valid_i), .reg_rdata_o(reg_rdata_o),
    .reg_error_o(reg_error_o), .reg_ready_o(reg_ready_o),
    .wr_timeout_i(wr_timeout_i), .rd_timeout_i(rd_timeout_i),
    .guard_en_o(guard_en_o), .wr_budget_o(wr_budget_o),
    .rd_budget_o(rd_budget_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic        err;
    logic        chk;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (reg_ready_o) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ready rdata=%h", reg_rdata_o);
      end else begin
        e = sb.pop_front();
        if (reg_error_o !== e.err ||
            (e.chk && reg_rdata_o !== e.rdata)) begin
          n_fail++;
          $display("FAIL resp@%h act rdata=%h err=%b exp rdata=%h err=%b",
                   e.addr, reg_rdata_o, reg_error_o, e.rdata, e.err);
        end
      end
    end
  end

  task automatic access(input logic [7:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] er, input logic ee,
                        input logic pw);
    exp_t e;
    int n;
    @(negedge clk_i);
    reg_addr_i  = {24'd0, a};
    reg_write_i = w;
    reg_wdata_i = d;
    reg_wstrb_i = s;
    reg_valid_i = 1'b1;
    e.addr = a; e.rdata = er; e.err = ee; e.chk = !w;
    sb.push_back(e);
    n = 0;
    do begin
      @(posedge clk_i); #1; n++;
    end while (!reg_ready_o && n < 8);
    chk("latency", n, 1);
    @(negedge clk_i);
    reg_valid_i = 1'b0;
    if (pw) wr_timeout_i = 1'b1;
    @(posedge clk_i); #1;
    wr_timeout_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic ee);
    access(a, 1'b1, d, s, 32'd0, ee, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] er,
                    input logic ee);
    access(a, 1'b0, 32'd0, 4'h0, er, ee, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    chk("rst_guard_en", 32'(guard_en_o), 0);
    chk("rst_wr_budget", 32'(wr_budget_o), 0);
    chk("rst_rd_budget", 32'(rd_budget_o), 0);
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_ready", 32'(reg_ready_o), 0);

    for (int i = 0; i < 7; i++)
      rd(8'(i * 4), (i == 6) ? ID : 32'd0, 1'b0);

    wr(8'h04, 32'h0000_0001, 4'hF, 1'b0);
    chk("wr_budget_1", 32'(wr_budget_o), 1);
    wr(8'h00, 32'h0000_0001, 4'hF, 1'b0);
    chk("guard_en_1", 32'(guard_en_o), 1);
    wr(8'h04, 32'hFFFF_FF01, 4'h1, 1'b0);
    chk("wr_budget_strb", 32'(wr_budget_o), 1);
    wr(8'h04, 32'h0000_03FF, 4'h0, 1'b0);
    chk("wr_budget_nostrb", 32'(wr_budget_o), 1);
    wr(8'h08, 32'h0000_0312, 4'h2, 1'b0);
    chk("rd_budget_byte1", 32'(rd_budget_o), 32'h300);
    rd(8'h08, 32'h0000_0300, 1'b0);

    wr(8'h10, 32'h1, 4'hF, 1'b0);
    rd(8'h10, 32'h1, 1'b0);
    @(negedge clk_i) wr_timeout_i = 1'b1;
    @(posedge clk_i); #1;
    chk("irq_lag", 32'(irq_o), 0);
    @(negedge clk_i) wr_timeout_i = 1'b0;
    @(posedge clk_i); #1;
    chk("irq_set", 32'(irq_o), 1);
    repeat (2) begin
      @(negedge clk_i) wr_timeout_i = 1'b1;
      @(negedge clk_i) wr_timeout_i = 1'b0;
    end
    rd(8'h0C, 32'h1, 1'b0);
    rd(8'h14, 32'h0000_0003, 1'b0);
    wr(8'h0C, 32'h1, 4'hF, 1'b0);
    chk("irq_hold", 32'(irq_o), 1);
    @(posedge clk_i); #1;
    chk("irq_fall", 32'(irq_o), 0);
    rd(8'h0C, 32'h0, 1'b0);

    access(8'h0C, 1'b1, 32'h1, 4'hF, 32'd0, 1'b0, 1'b1);
    rd(8'h0C, 32'h1, 1'b0);
    rd(8'h14, 32'h0000_0004, 1'b0);
    access(8'h14, 1'b1, 32'h0, 4'h0, 32'd0, 1'b0, 1'b1);
    rd(8'h14, 32'h0000_0001, 1'b0);

    @(negedge clk_i) rd_timeout_i = 1'b1;
    repeat (65600) @(posedge clk_i);
    @(negedge clk_i) rd_timeout_i = 1'b0;
    rd(8'h14, 32'hFFFF_0001, 1'b0);
    rd(8'h0C, 32'h3, 1'b0);

    rd(8'h02, 32'h0, 1'b1);
    rd(8'h1C, 32'h0, 1'b1);
    wr(8'h18, 32'h0, 4'hF, 1'b1);
    rd(8'h18, ID, 1'b0);
    wr(8'h05, 32'hFF, 4'hF, 1'b1);
    chk("err_no_change", 32'(wr_budget_o), 1);

    wr(8'h00, 32'h8000_0001, 4'hF, 1'b0);
`ifdef GUARD_CFG_LOCK_EN
    rd(8'h00, 32'h8000_0001, 1'b0);
    wr(8'h04, 32'h5, 4'hF, 1'b1);
    chk("lock_wr_budget", 32'(wr_budget_o), 1);
`else
    rd(8'h00, 32'h0000_0001, 1'b0);
    wr(8'h04, 32'h5, 4'hF, 1'b0);
    chk("nolock_wr_budget", 32'(wr_budget_o), 5);
`endif
    wr(8'h0C, 32'h3, 4'hF, 1'b0);
    rd(8'h0C, 32'h0, 1'b0);

    @(negedge clk_i);
    reg_addr_i  = 32'h08;
    reg_write_i = 1'b1;
    reg_wdata_i = 32'h155;
    reg_wstrb_i = 4'hF;
    reg_valid_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(reg_ready_o), 0);
    reg_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i) rst_i = 1'b0;
    chk("rst_mid_rd_budget", 32'(rd_budget_o), 0);
    rd(8'h08, 32'h0, 1'b0);
    chk("rst_mid_guard_en", 32'(guard_en_o), 0);

    repeat (3) @(posedge clk_i);
    chk("sb_drain", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
